// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and access sequencer in front of the
// byte-addressed data memory `ram`.
//   - p0 (load/store unit) and p1 (debug/loader) share one memory port.
//   - Halfword stores are issued as two byte writes (low byte, then addr+1).
//   - Byte/halfword loads are optionally sign-extended.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req/we/type/sext/addr/wdata_pX requester command (held until gnt_pX)
//   gnt/done/err/rdata_pX         per-port handshake and load result
//   mem_we/mem_type/mem_a/mem_wd  memory command, mem_rd combinational read
//   busy                          FSM is not IDLE
// Configuration:
//   DMEM_ARB_ROUND_ROBIN_EN  defined: round-robin tie break;
//                            undefined: fixed priority, p0 wins ties.
module dmem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_p0,
  input  logic                     we_p0,
  input  logic [1:0]               type_p0,
  input  logic                     sext_p0,
  input  logic [ADDRESS_WIDTH-1:0] addr_p0,
  input  logic [DATA_WIDTH-1:0]    wdata_p0,
  input  logic                     req_p1,
  input  logic                     we_p1,
  input  logic [1:0]               type_p1,
  input  logic                     sext_p1,
  input  logic [ADDRESS_WIDTH-1:0] addr_p1,
  input  logic [DATA_WIDTH-1:0]    wdata_p1,
  output logic                     gnt_p0,
  output logic                     done_p0,
  output logic                     err_p0,
  output logic [DATA_WIDTH-1:0]    rdata_p0,
  output logic                     gnt_p1,
  output logic                     done_p1,
  output logic                     err_p1,
  output logic [DATA_WIDTH-1:0]    rdata_p1,
  output logic                     mem_we,
  output logic [1:0]               mem_type,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  input  logic [DATA_WIDTH-1:0]    mem_rd,
  output logic                     busy
);
  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, ACCESS_HI = 2'd2} state_e;

  typedef struct packed {
    logic          port;
    logic          we;
    logic [1:0]    typ;
    logic          sext;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  state_e             state_q, state_d;
  cmd_t               cmd_q, cmd_d, cand;
  logic [1:0]         gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic [1:0][DW-1:0] rdata_q, rdata_d;
  logic               any_req, win, illegal, mem_we_raw;
  logic [DW-1:0]      ld_data;

  assign any_req = req_p0 | req_p1;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // ptr_q names the port that wins the next tie; it flips to the other
  // port on every grant, so a tie always goes to the port not served last.
  logic ptr_q;
  always_comb win = (req_p0 & req_p1) ? ptr_q : req_p1;
  always_ff @(posedge clk) begin
    if (rst)                            ptr_q <= 1'b0;
    else if (state_q == IDLE && any_req) ptr_q <= ~win;
  end
`else
  assign win = ~req_p0;
`endif

  always_comb begin
    cand      = '0;
    cand.port = win;
    if (win) begin
      cand.we = we_p1; cand.typ = type_p1; cand.sext = sext_p1;
      cand.addr = addr_p1; cand.wdata = wdata_p1;
    end else begin
      cand.we = we_p0; cand.typ = type_p0; cand.sext = sext_p0;
      cand.addr = addr_p0; cand.wdata = wdata_p0;
    end
  end

  assign illegal = (cmd_q.typ == 2'b11) ||
                   (cmd_q.typ == 2'b00 && cmd_q.addr[1:0] != 2'b00) ||
                   (cmd_q.typ == 2'b10 && cmd_q.addr[0]);

  // ram zero-extends narrow reads; mask anyway so the result does not
  // depend on what the memory returns above the accessed width.
  always_comb begin
    case (cmd_q.typ)
      2'b01:   ld_data = {{(DW-8){cmd_q.sext & mem_rd[7]}}, mem_rd[7:0]};
      2'b10:   ld_data = {{(DW-16){cmd_q.sext & mem_rd[15]}}, mem_rd[15:0]};
      default: ld_data = mem_rd;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    gnt_d      = '0;
    done_d     = '0;
    err_d      = '0;
    rdata_d    = rdata_q;
    mem_we_raw = 1'b0;
    mem_type   = 2'b00;
    mem_a      = '0;
    mem_wd     = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          cmd_d      = cand;
          gnt_d[win] = 1'b1;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        state_d = IDLE;
        if (illegal) begin
          // memory port stays at its idle values
          done_d[cmd_q.port] = 1'b1;
          err_d[cmd_q.port]  = 1'b1;
        end else begin
          mem_a = cmd_q.addr;
          if (!cmd_q.we) begin
            mem_type            = cmd_q.typ;
            rdata_d[cmd_q.port] = ld_data;
            done_d[cmd_q.port]  = 1'b1;
          end else if (cmd_q.typ == 2'b10) begin
            // low byte of a halfword store; high byte follows at addr+1
            mem_type   = 2'b01;
            mem_we_raw = 1'b1;
            mem_wd     = {{(DW-8){1'b0}}, cmd_q.wdata[7:0]};
            state_d    = ACCESS_HI;
          end else begin
            mem_type           = cmd_q.typ;
            mem_we_raw         = 1'b1;
            mem_wd             = cmd_q.wdata;
            done_d[cmd_q.port] = 1'b1;
          end
        end
      end
      ACCESS_HI: begin
        mem_a              = cmd_q.addr + AW'(1);
        mem_type           = 2'b01;
        mem_we_raw         = 1'b1;
        mem_wd             = {{(DW-8){1'b0}}, cmd_q.wdata[15:8]};
        done_d[cmd_q.port] = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Gate the write strobe with reset so a reset landing during ACCESS_HI
  // suppresses the high-byte write at that same edge.
  assign mem_we = mem_we_raw & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign gnt_p0   = gnt_q[0];
  assign gnt_p1   = gnt_q[1];
  assign done_p0  = done_q[0];
  assign done_p1  = done_q[1];
  assign err_p0   = err_q[0];
  assign err_p1   = err_q[1];
  assign rdata_p0 = rdata_q[0];
  assign rdata_p1 = rdata_q[1];
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: byte-array memory model plus a transaction
// level reference (shadow memory, expected rdata, last-served port).
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_p0, we_p0, sext_p0, req_p1, we_p1, sext_p1;
  logic [1:0]    type_p0, type_p1;
  logic [AW-1:0] addr_p0, addr_p1;
  logic [DW-1:0] wdata_p0, wdata_p1;
  logic          gnt_p0, done_p0, err_p0, gnt_p1, done_p1, err_p1;
  logic [DW-1:0] rdata_p0, rdata_p1;
  logic          mem_we, busy;
  logic [1:0]    mem_type;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd, mem_rd;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_p0(req_p0), .we_p0(we_p0), .type_p0(type_p0), .sext_p0(sext_p0),
    .addr_p0(addr_p0), .wdata_p0(wdata_p0),
    .req_p1(req_p1), .we_p1(we_p1), .type_p1(type_p1), .sext_p1(sext_p1),
    .addr_p1(addr_p1), .wdata_p1(wdata_p1),
    .gnt_p0(gnt_p0), .done_p0(done_p0), .err_p0(err_p0), .rdata_p0(rdata_p0),
    .gnt_p1(gnt_p1), .done_p1(done_p1), .err_p1(err_p1), .rdata_p1(rdata_p1),
    .mem_we(mem_we), .mem_type(mem_type), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd), .busy(busy)
  );

  // ---------------- memory (little-endian, 64 KiB window) ----------------
  logic [7:0] ram [0:65535];
  int         nwr = 0;

  always_comb begin
    case (mem_type)
      2'b01:   mem_rd = {24'b0, ram[mem_a[15:0]]};
      2'b10:   mem_rd = {16'b0, ram[mem_a[15:0] + 16'd1], ram[mem_a[15:0]]};
      default: mem_rd = {ram[mem_a[15:0] + 16'd3], ram[mem_a[15:0] + 16'd2],
                         ram[mem_a[15:0] + 16'd1], ram[mem_a[15:0]]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_we) begin
      nwr = nwr + 1;
      if (mem_type == 2'b01) ram[mem_a[15:0]] = mem_wd[7:0];
      else if (mem_type == 2'b00) begin
        for (int i = 0; i < 4; i++) ram[mem_a[15:0] + 16'(i)] = mem_wd[8*i +: 8];
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit        we;
    bit [1:0]  typ;
    bit        sext;
    bit [31:0] addr;
    bit [31:0] wdata;
  } cmd_t;

  logic [7:0]  sh [0:65535];
  logic [31:0] exp_rd [2];
  int          last_srv;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input bit we, input bit [1:0] typ, input bit sext,
                              input bit [31:0] addr, input bit [31:0] wdata);
    cmd_t c;
    c.we = we; c.typ = typ; c.sext = sext; c.addr = addr; c.wdata = wdata;
    return c;
  endfunction

  function automatic bit is_illegal(input cmd_t c);
    return (c.typ == 2'b11) || (c.typ == 2'b00 && c.addr[1:0] != 2'b00) ||
           (c.typ == 2'b10 && c.addr[0]);
  endfunction

  function automatic int lat(input cmd_t c);
    return (!is_illegal(c) && c.we && c.typ == 2'b10) ? 3 : 2;
  endfunction

  function automatic int tie_winner();
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    return (last_srv == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic model_exec(input int p, input cmd_t c, output int writes);
    int n;
    logic [31:0] v;
    logic [15:0] a;
    writes = 0;
    if (is_illegal(c)) return;
    n = (c.typ == 2'b00) ? 4 : (c.typ == 2'b01) ? 1 : 2;
    if (c.we) begin
      for (int i = 0; i < n; i++) begin
        a = c.addr[15:0] + 16'(i);
        sh[a] = c.wdata[8*i +: 8];
      end
      writes = (c.typ == 2'b10) ? 2 : 1;
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) begin
        a = c.addr[15:0] + 16'(i);
        v = v | (32'(sh[a]) << (8*i));
      end
      if (c.sext && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      exp_rd[p] = v;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input int p, input cmd_t c);
    if (p == 0) begin
      we_p0 = c.we; type_p0 = c.typ; sext_p0 = c.sext; addr_p0 = c.addr;
      wdata_p0 = c.wdata; req_p0 = 1'b1;
    end else begin
      we_p1 = c.we; type_p1 = c.typ; sext_p1 = c.sext; addr_p1 = c.addr;
      wdata_p1 = c.wdata; req_p1 = 1'b1;
    end
  endtask

  task automatic drop(input int p);
    if (p == 0) req_p0 = 1'b0; else req_p1 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_p0 = 1'b0; req_p1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    last_srv = 1;
  endtask

  // One transaction per used port, both raised in the same cycle; the
  // model fixes the service order and the exact gnt/done cycle of each.
  task automatic run(input bit u0, input bit u1, input cmd_t c0, input cmd_t c1);
    cmd_t c[2];
    bit   u[2];
    int   g[2], d[2];
    int   w, l, wr, wr_exp, n0, last_cyc;
    logic [15:0] a;
    c[0] = c0; c[1] = c1; u[0] = u0; u[1] = u1;
    w = (u0 && u1) ? tie_winner() : (u1 ? 1 : 0);
    l = 1 - w;
    g[w] = 1; d[w] = lat(c[w]);
    model_exec(w, c[w], wr); wr_exp = wr; last_srv = w;
    if (u[l]) begin
      g[l] = d[w] + 1; d[l] = d[w] + lat(c[l]);
      model_exec(l, c[l], wr); wr_exp += wr; last_srv = l;
      last_cyc = d[l];
    end else begin
      g[l] = -1; d[l] = -1; last_cyc = d[w];
    end
    n0 = nwr;
    for (int p = 0; p < 2; p++) if (u[p]) drive(p, c[p]);
    for (int cyc = 1; cyc <= last_cyc; cyc++) begin
      @(posedge clk); #1;
      chk("busy", 32'(busy), 32'((cyc >= g[0] && cyc < d[0]) || (cyc >= g[1] && cyc < d[1])));
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("gnt_p%0d", p), 32'(p == 0 ? gnt_p0 : gnt_p1), 32'(cyc == g[p]));
        chk($sformatf("done_p%0d", p), 32'(p == 0 ? done_p0 : done_p1), 32'(cyc == d[p]));
        if (cyc == d[p]) begin
          chk($sformatf("err_p%0d", p), 32'(p == 0 ? err_p0 : err_p1), 32'(is_illegal(c[p])));
          chk($sformatf("rdata_p%0d", p), p == 0 ? rdata_p0 : rdata_p1, exp_rd[p]);
        end
        if (cyc == g[p]) drop(p);
      end
    end
    chk("write_count", 32'(nwr - n0), 32'(wr_exp));
    for (int p = 0; p < 2; p++) begin
      if (u[p] && c[p].we) begin
        for (int i = 0; i < 4; i++) begin
          a = c[p].addr[15:0] + 16'(i);
          chk($sformatf("ram[%h]", a), 32'(ram[a]), 32'(sh[a]));
        end
      end
    end
  endtask

  cmd_t rc0, rc1, nul;

  function automatic cmd_t rnd_cmd();
    bit [1:0]  t;
    bit [31:0] a;
    t = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
    a = 32'h1000 + ($urandom % 64);
    if ($urandom % 4 != 0) begin
      if (t == 2'b00) a[1:0] = 2'b00;
      else if (t == 2'b10) a[0] = 1'b0;
    end
    return mk(1'($urandom % 2), t, 1'($urandom % 2), a, $urandom);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n0;
    logic [7:0] old5;
    for (int i = 0; i < 65536; i++) begin ram[i] = 8'h00; sh[i] = 8'h00; end
    nul = mk(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    we_p0 = 0; type_p0 = 0; sext_p0 = 0; addr_p0 = 0; wdata_p0 = 0;
    we_p1 = 0; type_p1 = 0; sext_p1 = 0; addr_p1 = 0; wdata_p1 = 0;
    do_reset();

    // reset state
    chk("rst_gnt", {30'b0, gnt_p1, gnt_p0}, 32'd0);
    chk("rst_done", {30'b0, done_p1, done_p0}, 32'd0);
    chk("rst_err", {30'b0, err_p1, err_p0}, 32'd0);
    chk("rst_rdata0", rdata_p0, 32'd0);
    chk("rst_rdata1", rdata_p1, 32'd0);
    chk("rst_mem", {29'b0, mem_we, mem_type}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // word store then load on p0
    run(1, 0, mk(1, 2'b00, 0, 32'h1000, 32'hDEADBEEF), nul);
    run(1, 0, mk(0, 2'b00, 0, 32'h1000, 32'h0), nul);
    chk("dir_word_ld", rdata_p0, 32'hDEADBEEF);

    // halfword store then signed/unsigned halfword load on p1
    run(0, 1, nul, mk(1, 2'b10, 0, 32'h1002, 32'h1234_8001));
    chk("dir_hw_lo", 32'(ram[16'h1002]), 32'h01);
    chk("dir_hw_hi", 32'(ram[16'h1003]), 32'h80);
    run(0, 1, nul, mk(0, 2'b10, 1, 32'h1002, 32'h0));
    chk("dir_hw_sext", rdata_p1, 32'hFFFF8001);
    run(0, 1, nul, mk(0, 2'b10, 0, 32'h1002, 32'h0));
    chk("dir_hw_zext", rdata_p1, 32'h00008001);

    // illegal commands: misaligned word, type 11
    run(1, 0, mk(0, 2'b00, 0, 32'h1001, 32'h0), nul);
    run(1, 0, mk(1, 2'b11, 0, 32'h1000, 32'h5555_5555), nul);
    run(1, 0, mk(1, 2'b10, 0, 32'h1003, 32'h5555_5555), nul);
    chk("dir_illegal_rd", rdata_p0, 32'hDEADBEEF);

    // sustained contention with byte loads
    do_reset();
    drive(0, mk(0, 2'b01, 0, 32'h1000, 32'h0));
    drive(1, mk(0, 2'b01, 0, 32'h1003, 32'h0));
    for (int cyc = 1; cyc <= 16; cyc++) begin
      int ep;
      @(posedge clk); #1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      ep = ((cyc - 1) / 2) % 2;
`else
      ep = 0;
`endif
      chk("cont_gnt_p0", 32'(gnt_p0), 32'((cyc % 2 == 1) && ep == 0));
      chk("cont_gnt_p1", 32'(gnt_p1), 32'((cyc % 2 == 1) && ep == 1));
      if (cyc == 16) begin drop(0); drop(1); end
    end
    @(posedge clk); #1;
    chk("cont_idle", 32'(busy), 32'd0);
    do_reset();

    // randomized single and simultaneous traffic
    for (int it = 0; it < 250; it++) begin
      int mode;
      mode = $urandom % 3;
      rc0 = rnd_cmd();
      rc1 = rnd_cmd();
      run(mode != 1, mode != 0, rc0, rc1);
    end

    // reset during ACCESS_HI of a halfword store
    run(1, 0, mk(1, 2'b01, 0, 32'h1005, 32'h5A), nul);
    old5 = sh[16'h1005];
    n0 = nwr;
    drive(1, mk(1, 2'b10, 0, 32'h1004, 32'h7777_ABCD));
    @(posedge clk); #1;
    chk("rhi_gnt", 32'(gnt_p1), 32'd1);
    drop(1);
    @(posedge clk); #1;
    chk("rhi_mem_a", mem_a, 32'h1005);
    chk("rhi_mem_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rhi_flags", {26'b0, busy, mem_we, gnt_p1, gnt_p0, done_p1, done_p0}, 32'd0);
    chk("rhi_err", {30'b0, err_p1, err_p0}, 32'd0);
    chk("rhi_rdata0", rdata_p0, 32'd0);
    chk("rhi_rdata1", rdata_p1, 32'd0);
    chk("rhi_mem_a0", mem_a, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rhi_no_done", {30'b0, done_p1, done_p0}, 32'd0);
    end
    chk("rhi_lo", 32'(ram[16'h1004]), 32'hCD);
    chk("rhi_hi", 32'(ram[16'h1005]), 32'(old5));
    chk("rhi_writes", 32'(nwr - n0), 32'd1);
    sh[16'h1004] = 8'hCD;
    exp_rd[0] = '0; exp_rd[1] = '0; last_srv = 1;

    // traffic still works after the abort
    run(1, 1, mk(0, 2'b01, 0, 32'h1004, 32'h0), mk(0, 2'b10, 1, 32'h1004, 32'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
